// File: rtl/cv32e40s_pkg.sv
// Shared types for the iterative divider: opcodes, FSM states and captured operation control.
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        DIV_DIVU = 2'b00,
        DIV_DIV  = 2'b01,
        DIV_REMU = 2'b10,
        DIV_REM  = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_DIVIDE = 2'b01,
        DIV_FINISH = 2'b10
    } div_multi_state_e;

    // Operation control captured in DIV_IDLE and held for the whole operation
    typedef struct packed {
        div_opcode_e op;
        logic        quot_neg;
        logic        rem_neg;
    } div_ctrl_t;

    function automatic logic div_is_signed(div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_rem(div_opcode_e op);
        return (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage

// File: rtl/cv32e40s_div_step.sv
// One restoring division step: shift in a dividend bit, compare against the divisor, subtract.
module cv32e40s_div_step
    import cv32e40s_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;
    // Partial remainder is always below the divisor, so its top bit never carries information
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[WIDTH];
    assign rem_shift      = {rem_i[WIDTH-1:0], dividend_bit_i};
    assign rem_diff       = rem_shift - {1'b0, divisor_i};
    assign quot_bit_o     = (rem_shift >= {1'b0, divisor_i});
    assign rem_o          = quot_bit_o ? rem_diff : rem_shift;

endmodule

// File: rtl/cv32e40s_div_multi.sv
// Iterative DIV/DIVU/REM/REMU unit retiring 1 or 2 quotient bits per cycle.
// Define CV32E40S_DIV_EARLY_TERM_EN to build dividend CLZ based early termination.
module cv32e40s_div_multi
    import cv32e40s_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  div_opcode_e       operator_i,
    input  logic              data_ind_timing_i,
    input  logic [WIDTH-1:0]  op_a_i,
    input  logic [WIDTH-1:0]  op_b_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  result_o
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned N_FULL = WIDTH / BITS_PER_CYCLE;

    if (!((WIDTH == 32) || (WIDTH == 64))) begin : g_bad_width
        $error("cv32e40s_div_multi: WIDTH must be 32 or 64");
    end
    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2))) begin : g_bad_bpc
        $error("cv32e40s_div_multi: BITS_PER_CYCLE must be 1 or 2");
    end

    div_multi_state_e  state_q, state_d;
    div_ctrl_t         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load;
    logic              step_en;

    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [WIDTH-1:0]  dividend_init;
    logic [CNT_W-1:0]  cnt_init;

    assign op_signed = div_is_signed(operator_i);
    assign a_neg     = op_signed & op_a_i[WIDTH-1];
    assign b_neg     = op_signed & op_b_i[WIDTH-1];
    assign abs_a     = a_neg ? WIDTH'(-op_a_i) : op_a_i;
    assign abs_b     = b_neg ? WIDTH'(-op_b_i) : op_b_i;

`ifdef CV32E40S_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] clz;
    logic [CNT_W-1:0] shamt;
    logic             et_en;

    // Leading zeros of |a|; the highest set bit wins
    always_comb begin
        clz = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) begin
                clz = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    // Keep at least one iteration and whole multi-bit steps
    always_comb begin
        shamt = (clz > CNT_W'(WIDTH - BITS_PER_CYCLE)) ? CNT_W'(WIDTH - BITS_PER_CYCLE) : clz;
        if (BITS_PER_CYCLE == 2) begin
            shamt[0] = 1'b0;
        end
    end

    assign et_en         = !data_ind_timing_i && (op_b_i != '0);
    assign dividend_init = et_en ? (abs_a << shamt) : abs_a;
    assign cnt_init      = et_en ? CNT_W'((WIDTH - 32'(shamt)) / BITS_PER_CYCLE) : CNT_W'(N_FULL);
`else
    logic unused_dit;

    assign unused_dit    = data_ind_timing_i;
    assign dividend_init = abs_a;
    assign cnt_init      = CNT_W'(N_FULL);
`endif

    logic [WIDTH:0]              rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0]   qbits;
    logic [WIDTH-1:0]            quot_step;
    logic [WIDTH-1:0]            rem_low;
    logic [WIDTH-1:0]            quot_fin;
    logic [WIDTH-1:0]            rem_fin;
    logic [WIDTH-1:0]            result_fin;

    assign rem_chain[0] = rem_q;

    // Cascaded restoring steps, MSB quotient bit first
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        cv32e40s_div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .rem_i          (rem_chain[k]),
            .dividend_bit_i (dividend_q[WIDTH-1-k]),
            .divisor_i      (divisor_q),
            .rem_o          (rem_chain[k+1]),
            .quot_bit_o     (qbits[BITS_PER_CYCLE-1-k])
        );
    end

    assign quot_step = (quot_q << BITS_PER_CYCLE) | WIDTH'(qbits);
    assign rem_low   = rem_chain[BITS_PER_CYCLE][WIDTH-1:0];

    always_comb begin
        quot_fin   = ctrl_q.quot_neg ? WIDTH'(-quot_step) : quot_step;
        rem_fin    = ctrl_q.rem_neg ? WIDTH'(-rem_low) : rem_low;
        result_fin = div_is_rem(ctrl_q.op) ? rem_fin : quot_fin;
    end

    // Control FSM; a dropped valid_i kills from any state
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        load    = 1'b0;
        step_en = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (valid_i) begin
                    load    = 1'b1;
                    state_d = DIV_DIVIDE;
                end
            end
            DIV_DIVIDE: begin
                step_en = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_FINISH;
                end
            end
            DIV_FINISH: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    ready_o = 1'b1;
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        if (!valid_i) begin
            state_d = DIV_IDLE;
            ready_o = 1'b1;
            valid_o = 1'b0;
            load    = 1'b0;
            step_en = 1'b0;
        end
    end

    // Datapath next state
    always_comb begin
        ctrl_d     = ctrl_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        if (load) begin
            ctrl_d.op       = operator_i;
            ctrl_d.quot_neg = op_signed & (a_neg ^ b_neg) & (op_b_i != '0);
            ctrl_d.rem_neg  = a_neg;
            divisor_d       = abs_b;
            dividend_d      = dividend_init;
            quot_d          = '0;
            rem_d           = '0;
            cnt_d           = cnt_init;
        end else if (step_en) begin
            dividend_d = dividend_q << BITS_PER_CYCLE;
            quot_d     = quot_step;
            rem_d      = rem_chain[BITS_PER_CYCLE];
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                result_d = result_fin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            ctrl_q     <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_cv32e40s_div_multi.sv
// Scoreboard bench for cv32e40s_div_multi: results, latency, stall, kill and reset behaviour.
module tb_cv32e40s_div_multi;
    import cv32e40s_pkg::*;

    localparam int TB_W   = 32;
    localparam int TB_BPC = 1;
`ifdef CV32E40S_DIV_EARLY_TERM_EN
    localparam bit TB_ET = 1'b1;
`else
    localparam bit TB_ET = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    div_opcode_e operator_i;
    logic        data_ind_timing_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int total;
    int bad;
    logic [31:0] exp_q [$];

    cv32e40s_div_multi #(
        .WIDTH          (TB_W),
        .BITS_PER_CYCLE (TB_BPC)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .operator_i        (operator_i),
        .data_ind_timing_i (data_ind_timing_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .result_o          (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(div_opcode_e op, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        logic [31:0]        r;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIV_DIVU: r = (b == '0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: r = (b == '0) ? a : a % b;
            DIV_DIV:  r = (b == '0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            default:  r = (b == '0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
        endcase
        return r;
    endfunction

    function automatic int model_latency(div_opcode_e op, logic [31:0] a, logic [31:0] b, logic dit);
        logic [31:0] mag;
        int          lz;
        int          s;
        if (!TB_ET || dit || (b == '0)) return TB_W / TB_BPC + 1;
        mag = (((op == DIV_DIV) || (op == DIV_REM)) && a[31]) ? -a : a;
        lz  = 0;
        while ((lz < 32) && !mag[31-lz]) lz++;
        s = (lz > TB_W - TB_BPC) ? (TB_W - TB_BPC) : lz;
        s = s - (s % TB_BPC);
        return (TB_W - s) / TB_BPC + 1;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge with valid_i still high
    task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic dit, input int stall, input string tag);
        int          cycles;
        int          exp_lat;
        logic [31:0] held;
        logic [31:0] exp;
        operator_i        = op;
        op_a_i            = a;
        op_b_i            = b;
        data_ind_timing_i = dit;
        valid_i           = 1'b1;
        ready_i           = 1'b0;
        exp_q.push_back(model_result(op, a, b));
        exp_lat = model_latency(op, a, b, dit);
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                op_a_i = $urandom;
                op_b_i = $urandom;
            end
        end while (!valid_o && (cycles < 200));
        total++;
        if (!valid_o) begin
            bad++;
            $display("FAIL %s timeout: no valid_o after %0d cycles", tag, cycles);
            void'(exp_q.pop_front());
            valid_i = 1'b0;
            @(negedge clk);
            return;
        end
        total++;
        if (cycles !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, cycles, exp_lat);
        end
        held = result_o;
        for (int i = 0; i < stall; i++) begin
            total++;
            if ((valid_o !== 1'b1) || (ready_o !== 1'b0) || (result_o !== held)) begin
                bad++;
                $display("FAIL %s stall%0d: valid_o=%b ready_o=%b result=%h want 1 0 %h",
                         tag, i, valid_o, ready_o, result_o, held);
            end
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_o on accept: got %b want 1", tag, ready_o);
        end
        exp = exp_q.pop_front();
        total++;
        if (result_o !== exp) begin
            bad++;
            $display("FAIL %s result: got %h want %h", tag, result_o, exp);
        end
        @(negedge clk);
        ready_i = 1'b0;
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s valid_o after accept: got %b want 0", tag, valid_o);
        end
    endtask

    task automatic go_idle();
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        valid_i           = 1'b0;
        ready_i           = 1'b0;
        operator_i        = DIV_DIVU;
        op_a_i            = '0;
        op_b_i            = '0;
        data_ind_timing_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ((ready_o !== 1'b1) || (valid_o !== 1'b0) || (result_o !== 32'h0)) begin
            bad++;
            $display("FAIL reset: ready_o=%b valid_o=%b result=%h want 1 0 0", ready_o, valid_o, result_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run_op(DIV_DIVU, 32'd100, 32'd7, 1'b1, 0, "divu_100_7");
        run_op(DIV_REMU, 32'd100, 32'd7, 1'b1, 0, "remu_100_7");
        go_idle();
    endtask

    task automatic test_signed();
        run_op(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
        run_op(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "rem_ovf");
        run_op(DIV_DIV, -32'sd7, 32'd2, 1'b0, 0, "div_m7_2");
        run_op(DIV_REM, -32'sd7, 32'd2, 1'b0, 0, "rem_m7_2");
        go_idle();
    endtask

    task automatic test_div_zero();
        run_op(DIV_DIVU, 32'd5, 32'd0, 1'b0, 0, "divu_5_0");
        run_op(DIV_REM, -32'sd5, 32'd0, 1'b0, 0, "rem_m5_0");
        run_op(DIV_DIV, -32'sd5, 32'd0, 1'b0, 0, "div_m5_0");
        go_idle();
    endtask

    task automatic test_early_term();
        run_op(DIV_DIVU, 32'd3, 32'd1, 1'b0, 0, "et_divu_3_1");
        run_op(DIV_DIVU, 32'd3, 32'd1, 1'b1, 0, "dit_divu_3_1");
        run_op(DIV_REMU, 32'd0, 32'd9, 1'b0, 0, "et_remu_0_9");
        go_idle();
    endtask

    task automatic test_kill();
        operator_i        = DIV_DIVU;
        op_a_i            = 32'hFFFF_0000;
        op_b_i            = 32'd3;
        data_ind_timing_i = 1'b1;
        valid_i           = 1'b1;
        ready_i           = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ((ready_o !== 1'b0) || (valid_o !== 1'b0)) begin
            bad++;
            $display("FAIL kill busy: ready_o=%b valid_o=%b want 0 0", ready_o, valid_o);
        end
        valid_i = 1'b0;
        #1;
        total++;
        if ((ready_o !== 1'b1) || (valid_o !== 1'b0)) begin
            bad++;
            $display("FAIL kill outputs: ready_o=%b valid_o=%b want 1 0", ready_o, valid_o);
        end
        @(negedge clk);
        total++;
        if (u_dut.state_q !== DIV_IDLE) begin
            bad++;
            $display("FAIL kill state: got %0d want %0d", u_dut.state_q, DIV_IDLE);
        end
        run_op(DIV_DIVU, 32'd9, 32'd3, 1'b0, 0, "after_kill");
        go_idle();
    endtask

    task automatic test_reset_mid();
        operator_i        = DIV_DIVU;
        op_a_i            = 32'd1000;
        op_b_i            = 32'd7;
        data_ind_timing_i = 1'b1;
        valid_i           = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ((valid_o !== 1'b0) || (result_o !== 32'h0) || (u_dut.state_q !== DIV_IDLE)) begin
            bad++;
            $display("FAIL reset_mid: valid_o=%b result=%h state=%0d want 0 0 %0d",
                     valid_o, result_o, u_dut.state_q, DIV_IDLE);
        end
        valid_i = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid ready_o: got %b want 1", ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall();
        run_op(DIV_DIV, -32'sd1000, 32'd7, 1'b0, 4, "stall_div");
        run_op(DIV_REMU, 32'hDEAD_BEEF, 32'h0001_2345, 1'b1, 2, "stall_remu");
        go_idle();
    endtask

    task automatic test_back_to_back();
        div_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            op = div_opcode_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (i == 3) b = '0;
            if (i == 5) b = 32'hFFFF_FFFF;
            if (i == 7) a = 32'h8000_0000;
            run_op(op, a, b, 1'($urandom_range(0, 1)), 0, "b2b");
        end
        go_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_early_term();
        test_kill();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40s_div_multi.md
# cv32e40s_div_multi

Parametrised iterative integer divider for the M-extension DIV/DIVU/REM/REMU operations. It is the successor of the single-bit serial divider. It supports a configurable operand width, retires 1 or 2 quotient bits per cycle, and contains its own leading-zero counter, so it no longer borrows ALU CLZ/shifter logic. It sits in the EX stage beside the multiplier and uses the same valid/ready/kill handshake.

## Interface
- WIDTH, 32: operand/result width; legal values are 32 and 64.
- BITS_PER_CYCLE, 1: quotient bits retired per DIVIDE cycle; legal values are 1 and 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- operator_i  in  div_opcode_e  DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU.
- data_ind_timing_i  in  1  forces fixed latency independent of operand values.
- op_a_i  in  WIDTH  dividend.
- op_b_i  in  WIDTH  divisor.
- valid_i  in  1  operation request; must be held high until the result is accepted; low = kill.
- ready_o  out  1  operation done/accepted, or unit free.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  WIDTH  quotient or remainder.

## Operation
- States: DIV_IDLE, DIV_DIVIDE, DIV_FINISH.
- DIV_IDLE with valid_i=1, one cycle:
  - Capture the opcode, |a| and |b| (unsigned view for DIVU/REMU).
  - Capture the sign flags: quot_neg = signed & (a_sign ^ b_sign) & (b != 0); rem_neg = signed & a_sign.
  - Load the iteration counter. Go to DIV_DIVIDE.
- Iteration count N, default: WIDTH/BITS_PER_CYCLE.
- Iteration count N with early termination active (see Configuration):
  - s = clz(|a|), capped at WIDTH-BITS_PER_CYCLE, then rounded down to a multiple of BITS_PER_CYCLE.
  - The dividend is pre-shifted left by s.
  - N = (WIDTH-s)/BITS_PER_CYCLE.
- Early termination is disabled when op_b_i == 0 or when data_ind_timing_i = 1.
- DIV_DIVIDE, per cycle, BITS_PER_CYCLE cascaded restoring steps:
  - rem = {rem[WIDTH-1:0], next dividend bit}.
  - If rem >= |b|: rem -= |b| and the quotient bit is 1; otherwise the quotient bit is 0.
  - The remainder register is WIDTH+1 bits.
  - When the counter reaches 0 after the last step, go to DIV_FINISH.
- DIV_FINISH:
  - result_o = REM ? (rem_neg ? -rem : rem) : (quot_neg ? -quot : quot).
  - valid_o = 1. If ready_i = 1, ready_o = 1 and go to DIV_IDLE.
- Boundary results, which fall out of the datapath with no special casing:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Kill: valid_i = 0 in any state forces next state DIV_IDLE, ready_o = 1 and valid_o = 0. A kill mid-DIVIDE discards the partial result.
- ready_o is also 1 in DIV_IDLE whenever valid_i = 0.

## Timing
- Reset values: state DIV_IDLE; valid_o 0; ready_o 1 (valid_i low); result_o 0; all datapath registers 0.
- Latency from the first valid_i cycle to the first valid_o cycle is N+1 cycles.
- Fixed latency is WIDTH/BITS_PER_CYCLE+1 cycles: 33 for 32/1, 17 for 32/2, 33 for 64/2.
- valid_o holds, with result_o stable, until ready_i. ready_o coincides with the accepting cycle.
- Operand inputs are sampled only in DIV_IDLE. They may change afterwards.
- Back-to-back: a new operation may start in the cycle after acceptance.

## Configuration
- CV32E40S_DIV_EARLY_TERM_EN defined:
  - Dividend CLZ and pre-shift logic are compiled in.
  - Early termination applies when data_ind_timing_i = 0 and op_b_i != 0.
- Undefined:
  - No CLZ logic is built.
  - N = WIDTH/BITS_PER_CYCLE always; data_ind_timing_i has no effect.

## Structure
- Package cv32e40s_pkg:
  - Reuse div_opcode_e.
  - Add div_multi_state_e {DIV_IDLE, DIV_DIVIDE, DIV_FINISH}, 2 bits.
- Sub-module cv32e40s_div_step: one combinational compare/subtract/shift step, WIDTH-parameterised, instantiated BITS_PER_CYCLE times in a generate loop.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- WIDTH=32, BPC=1, DIVU 100/7, data_ind_timing_i=1 -> result 14 after exactly 33 cycles; REMU -> 2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1.
- DIVU 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB. With the macro on, latency is still the full 33 cycles.
- Macro on, data_ind_timing_i=0, WIDTH=32, BPC=2, DIVU 3/1 -> result 3 with N=1, valid_o on the 2nd cycle; with data_ind_timing_i=1 -> valid_o on the 17th cycle.
- Kill: drop valid_i in the 5th DIVIDE cycle -> ready_o=1 and state DIV_IDLE next cycle; the following DIVU 9/3 returns 3 with no corruption.
- Hold ready_i=0 for 4 cycles in DIV_FINISH -> valid_o and result_o stable; ready_o only when ready_i rises. Assert rst_n mid-DIVIDE -> all outputs at their reset values immediately.
